// File: rtl/control_signal_generator.sv
// Microcode decoder: turns the micro-step (T0..T4) and one-hot instruction-class
// flags into registered datapath control strobes.
module control_signal_generator (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       halted,
    input  logic       alu,
    input  logic       ld,
    input  logic       st,
    input  logic       push,
    input  logic       pop,
    input  logic       jump,
    input  logic       be,
    input  logic [2:0] state,
    output logic       instruction_end,
    output logic       fetch,
    output logic       decode,
    output logic       alu_control,
    output logic       reg_read,
    output logic       reg_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       pc_read,
    output logic       pc_write,
    output logic       push_s,
    output logic       pop_s
);

    typedef enum logic [2:0] {
        CLS_NONE,
        CLS_ALU,
        CLS_LD,
        CLS_ST,
        CLS_PUSH,
        CLS_POP,
        CLS_BRANCH
    } cls_t;

    cls_t cls;

    // Bit positions inside the packed strobe vector.
    localparam int B_END   = 11;
    localparam int B_FETCH = 10;
    localparam int B_DEC   = 9;
    localparam int B_ALU   = 8;
    localparam int B_RR    = 7;
    localparam int B_RW    = 6;
    localparam int B_MR    = 5;
    localparam int B_MW    = 4;
    localparam int B_PCR   = 3;
    localparam int B_PCW   = 2;
    localparam int B_PUSH  = 1;
    localparam int B_POP   = 0;

    logic [11:0] ctrl_next;
    logic [11:0] ctrl_reg;

    // Fixed priority: alu > ld > st > push > pop > jump > be.
    always_comb begin
        cls = CLS_NONE;
        if (alu)               cls = CLS_ALU;
        else if (ld)           cls = CLS_LD;
        else if (st)           cls = CLS_ST;
        else if (push)         cls = CLS_PUSH;
        else if (pop)          cls = CLS_POP;
        else if (jump || be)   cls = CLS_BRANCH;
    end

    always_comb begin
        ctrl_next = '0;
        if (!halted) begin
            case (state)
                3'd0: begin
                    ctrl_next[B_FETCH] = 1'b1;
                    ctrl_next[B_PCR]   = 1'b1;
                    ctrl_next[B_MR]    = 1'b1;
                end
                3'd1: begin
                    ctrl_next[B_DEC] = 1'b1;
                    ctrl_next[B_PCW] = 1'b1;
                end
                3'd2: begin
                    case (cls)
                        CLS_ALU: begin
                            ctrl_next[B_RR]  = 1'b1;
                            ctrl_next[B_ALU] = 1'b1;
                        end
                        CLS_LD, CLS_ST: ctrl_next[B_RR] = 1'b1;
                        CLS_PUSH: begin
                            ctrl_next[B_RR]   = 1'b1;
                            ctrl_next[B_PUSH] = 1'b1;
                        end
                        CLS_POP: begin
                            ctrl_next[B_POP] = 1'b1;
                            ctrl_next[B_MR]  = 1'b1;
                        end
                        CLS_BRANCH: begin
                            ctrl_next[B_PCW] = 1'b1;
                            ctrl_next[B_END] = 1'b1;
                        end
                        default: ctrl_next[B_END] = 1'b1;
                    endcase
                end
                3'd3: begin
                    case (cls)
                        CLS_ALU: begin
                            ctrl_next[B_ALU] = 1'b1;
                            ctrl_next[B_RW]  = 1'b1;
                            ctrl_next[B_END] = 1'b1;
                        end
                        CLS_LD: ctrl_next[B_MR] = 1'b1;
                        CLS_ST, CLS_PUSH: begin
                            ctrl_next[B_MW]  = 1'b1;
                            ctrl_next[B_END] = 1'b1;
                        end
                        CLS_POP: begin
                            ctrl_next[B_RW]  = 1'b1;
                            ctrl_next[B_END] = 1'b1;
                        end
                        default: ctrl_next = '0;
                    endcase
                end
                3'd4: begin
                    if (cls == CLS_LD) begin
                        ctrl_next[B_RW]  = 1'b1;
                        ctrl_next[B_END] = 1'b1;
                    end
                end
                default: ctrl_next = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ctrl_reg <= '0;
        else        ctrl_reg <= ctrl_next;
    end

    assign instruction_end = ctrl_reg[B_END];
    assign fetch           = ctrl_reg[B_FETCH];
    assign decode          = ctrl_reg[B_DEC];
    assign alu_control     = ctrl_reg[B_ALU];
    assign reg_read        = ctrl_reg[B_RR];
    assign reg_write       = ctrl_reg[B_RW];
    assign mem_read        = ctrl_reg[B_MR];
    assign mem_write       = ctrl_reg[B_MW];
    assign pc_read         = ctrl_reg[B_PCR];
    assign pc_write        = ctrl_reg[B_PCW];
    assign push_s          = ctrl_reg[B_PUSH];
    assign pop_s           = ctrl_reg[B_POP];

endmodule

// File: tb/tb_control_signal_generator.sv
// Directed bench for control_signal_generator with hand-computed strobe sets.
module tb_control_signal_generator;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       halted;
    logic       alu, ld, st, push, pop, jump, be;
    logic [2:0] state;
    logic       instruction_end, fetch, decode, alu_control, reg_read, reg_write;
    logic       mem_read, mem_write, pc_read, pc_write, push_s, pop_s;

    int total_cnt = 0;
    int bad_cnt   = 0;

    // Expected-value bits, in the order of the observed vector below.
    localparam logic [11:0] E_END  = 12'h800;
    localparam logic [11:0] E_FET  = 12'h400;
    localparam logic [11:0] E_DEC  = 12'h200;
    localparam logic [11:0] E_ALU  = 12'h100;
    localparam logic [11:0] E_RR   = 12'h080;
    localparam logic [11:0] E_RW   = 12'h040;
    localparam logic [11:0] E_MR   = 12'h020;
    localparam logic [11:0] E_MW   = 12'h010;
    localparam logic [11:0] E_PCR  = 12'h008;
    localparam logic [11:0] E_PCW  = 12'h004;
    localparam logic [11:0] E_PUSH = 12'h002;
    localparam logic [11:0] E_POP  = 12'h001;

    // Class flag vector order: {alu, ld, st, push, pop, jump, be}.
    localparam logic [6:0] F_NONE = 7'b0000000;
    localparam logic [6:0] F_ALU  = 7'b1000000;
    localparam logic [6:0] F_LD   = 7'b0100000;
    localparam logic [6:0] F_ST   = 7'b0010000;
    localparam logic [6:0] F_PUSH = 7'b0001000;
    localparam logic [6:0] F_POP  = 7'b0000100;
    localparam logic [6:0] F_JUMP = 7'b0000010;
    localparam logic [6:0] F_BE   = 7'b0000001;

    wire [11:0] obs = {instruction_end, fetch, decode, alu_control, reg_read, reg_write,
                       mem_read, mem_write, pc_read, pc_write, push_s, pop_s};

    control_signal_generator dut (
        .clk(clk), .rst_n(rst_n), .halted(halted),
        .alu(alu), .ld(ld), .st(st), .push(push), .pop(pop), .jump(jump), .be(be),
        .state(state),
        .instruction_end(instruction_end), .fetch(fetch), .decode(decode),
        .alu_control(alu_control), .reg_read(reg_read), .reg_write(reg_write),
        .mem_read(mem_read), .mem_write(mem_write), .pc_read(pc_read),
        .pc_write(pc_write), .push_s(push_s), .pop_s(pop_s)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [11:0] got, input logic [11:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=%03h expected=%03h", tag, got, exp);
        end else begin
            $display("ok   %s: %03h", tag, got);
        end
    endtask

    // Drive one step at the falling edge, check the registered result after the rising edge.
    task automatic step(input string tag, input logic hlt, input logic [6:0] f,
                        input logic [2:0] s, input logic [11:0] exp);
        @(negedge clk);
        halted = hlt;
        {alu, ld, st, push, pop, jump, be} = f;
        state = s;
        @(posedge clk);
        #1;
        check_eq(tag, obs, exp);
    endtask

    initial begin
        rst_n = 1'b0;
        halted = 1'b0;
        {alu, ld, st, push, pop, jump, be} = F_NONE;
        state = 3'd0;

        #2  check_eq("reset_hold_a", obs, 12'h000);
        repeat (2) @(posedge clk);
        #1  check_eq("reset_hold_b", obs, 12'h000);
        @(negedge clk) rst_n = 1'b1;

        step("t0_fetch",      1'b0, F_NONE, 3'd0, E_FET | E_PCR | E_MR);
        step("t1_decode",     1'b0, F_ALU,  3'd1, E_DEC | E_PCW);
        step("t1_decode_st",  1'b0, F_ST,   3'd1, E_DEC | E_PCW);
        step("t1_halted",     1'b1, F_ALU,  3'd1, 12'h000);
        step("t0_halted",     1'b1, F_NONE, 3'd0, 12'h000);
        step("t3_halted",     1'b1, F_ALU,  3'd3, 12'h000);

        step("ld_t2",   1'b0, F_LD, 3'd2, E_RR);
        step("ld_t3",   1'b0, F_LD, 3'd3, E_MR);
        step("ld_t4",   1'b0, F_LD, 3'd4, E_RW | E_END);

        step("alu_t2",  1'b0, F_ALU,  3'd2, E_RR | E_ALU);
        step("alu_t3",  1'b0, F_ALU,  3'd3, E_ALU | E_RW | E_END);
        step("alu_t4",  1'b0, F_ALU,  3'd4, 12'h000);
        step("st_t2",   1'b0, F_ST,   3'd2, E_RR);
        step("st_t3",   1'b0, F_ST,   3'd3, E_MW | E_END);
        step("push_t2", 1'b0, F_PUSH, 3'd2, E_RR | E_PUSH);
        step("push_t3", 1'b0, F_PUSH, 3'd3, E_MW | E_END);
        step("pop_t2",  1'b0, F_POP,  3'd2, E_POP | E_MR);
        step("pop_t3",  1'b0, F_POP,  3'd3, E_RW | E_END);
        step("jump_t2", 1'b0, F_JUMP, 3'd2, E_PCW | E_END);
        step("jump_t3", 1'b0, F_JUMP, 3'd3, 12'h000);
        step("be_t2",   1'b0, F_BE,   3'd2, E_PCW | E_END);
        step("be_t3",   1'b0, F_BE,   3'd3, 12'h000);
        step("be_t4",   1'b0, F_BE,   3'd4, 12'h000);

        step("prio_alu_ld_push_t3", 1'b0, F_ALU | F_LD | F_PUSH, 3'd3, E_ALU | E_RW | E_END);
        step("prio_ld_st_t3",       1'b0, F_LD | F_ST,           3'd3, E_MR);
        step("prio_st_pop_t3",      1'b0, F_ST | F_POP,          3'd3, E_MW | E_END);
        step("prio_pop_jump_t2",    1'b0, F_POP | F_JUMP,        3'd2, E_POP | E_MR);
        step("prio_ld_all_t4",      1'b0, 7'b0111111,            3'd4, E_RW | E_END);
        step("nop_t2",              1'b0, F_NONE, 3'd2, E_END);
        step("nop_t3",              1'b0, F_NONE, 3'd3, 12'h000);

        // Illegal micro-steps: every flag combination must decode to nothing.
        for (int s = 5; s < 8; s++) begin
            for (int f = 0; f < 128; f++) begin
                step($sformatf("illegal_s%0d_f%02h", s, f), 1'b0, 7'(f), 3'(s), 12'h000);
            end
        end

        // Asynchronous reset mid-cycle while a store write is active.
        step("st_t3_before_rst", 1'b0, F_ST, 3'd3, E_MW | E_END);
        #1 rst_n = 1'b0;
        #1 check_eq("async_rst_mem_write", {11'b0, mem_write}, 12'h000);
        check_eq("async_rst_all", obs, 12'h000);
        @(posedge clk);
        #1 check_eq("rst_held_over_edge", obs, 12'h000);
        @(negedge clk);
        state = 3'd0;
        {alu, ld, st, push, pop, jump, be} = F_NONE;
        rst_n = 1'b1;
        @(posedge clk);
        #1 check_eq("resume_fetch", obs, E_FET | E_PCR | E_MR);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
